// File: rtl/ecap5_dproc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ecap5_dproc_pkg : load/store size codes and master FSM states    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package ecap5_dproc_pkg;

  localparam logic [1:0] LSM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LSM_SIZE_HALF = 2'd1;
  localparam logic [1:0] LSM_SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    WAIT_ACK = 3'd2,
    RESPOND  = 3'd3,
    ERROR    = 3'd4
  } lsm_state_t;

endpackage
`default_nettype wire

// File: rtl/lsm_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsm_align : byte-lane select, store replication, load extension  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsm_align
  import ecap5_dproc_pkg::*;
(
  input  logic [1:0]  req_off_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        misalign_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_ext_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    sel_o      = 4'b1111;
    dat_o      = req_wdata_i;
    misalign_o = 1'b0;
    case (req_size_i)
      LSM_SIZE_BYTE: begin
        sel_o = 4'b0001 << req_off_i;
        dat_o = {4{req_wdata_i[7:0]}};
      end
      LSM_SIZE_HALF: begin
        sel_o      = 4'b0011 << req_off_i;
        dat_o      = {2{req_wdata_i[15:0]}};
        misalign_o = req_off_i[0];
      end
      LSM_SIZE_WORD: misalign_o = |req_off_i;
      default:       misalign_o = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from the access width.
  always_comb begin
    ld_shifted = ld_data_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      LSM_SIZE_BYTE: ld_ext_o = {{24{ld_shifted[7] & ~ld_unsigned_i}}, ld_shifted[7:0]};
      LSM_SIZE_HALF: ld_ext_o = {{16{ld_shifted[15] & ~ld_unsigned_i}}, ld_shifted[15:0]};
      default:       ld_ext_o = ld_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsm_wb_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsm_wb_master : single-outstanding Wishbone pipelined LSU master |
// | Rev 1.0 ; optional watchdog when LSM_TIMEOUT_EN is defined       |
// +------------------------------------------------------------------+
module lsm_wb_master
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lsm_wb_master: TIMEOUT_CYCLES must be 1..65535");
  end

  lsm_state_t  state_q, state_d;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q, uns_q;
  logic [1:0]  off_q, size_q;
  logic [4:0]  rd_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [4:0]  rsp_rd_q;

  logic        accept, misalign, timeout;
  logic [3:0]  sel_w;
  logic [31:0] dat_w, ld_ext;

  lsm_align u_align (
    .req_off_i     (req_addr_i[1:0]),
    .req_size_i    (req_size_i),
    .req_wdata_i   (req_wdata_i),
    .sel_o         (sel_w),
    .dat_o         (dat_w),
    .misalign_o    (misalign),
    .ld_off_i      (off_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_data_i     (wb_dat_i),
    .ld_ext_o      (ld_ext)
  );

`ifdef LSM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt_q;

  // REQUEST is only entered from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                        tmo_cnt_q <= '0;
    else if (state_q == IDLE)                          tmo_cnt_q <= '0;
    else if (state_q == REQUEST || state_q == WAIT_ACK) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign timeout = (state_q == REQUEST || state_q == WAIT_ACK) &&
                   (tmo_cnt_q == TIMEOUT_LIM - 16'd1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        accept  = 1'b1;
        state_d = misalign ? ERROR : REQUEST;
      end
      REQUEST:  if (timeout) state_d = ERROR;
                else if (!wb_stall_i) state_d = WAIT_ACK;
      // An ack on the final watchdog cycle still completes the access.
      WAIT_ACK: if (wb_ack_i) state_d = RESPOND;
                else if (timeout) state_d = ERROR;
      RESPOND:  state_d = IDLE;
      ERROR:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      adr_q  <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      off_q  <= '0;
      size_q <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      adr_q  <= {req_addr_i[31:2], 2'b00};
      dat_q  <= dat_w;
      sel_q  <= sel_w;
      we_q   <= req_we_i;
      uns_q  <= req_unsigned_i;
      off_q  <= req_addr_i[1:0];
      size_q <= req_size_i;
      rd_q   <= req_rd_i;
    end
  end

  // Load data is extended at ack time, so no raw read buffer is needed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (state_q == WAIT_ACK && wb_ack_i) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= we_q ? 32'd0 : ld_ext;
        rsp_rd_q    <= rd_q;
      end else if (state_q == ERROR) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_rd_q    <= rd_q;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign wb_cyc_o    = (state_q == REQUEST) || (state_q == WAIT_ACK);
  assign wb_stb_o    = (state_q == REQUEST);
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_rd_o    = rsp_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_lsm_wb_master.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_lsm_wb_master : randomized bench with transaction-level model |
// | Rev 1.0 ; honours LSM_TIMEOUT_EN (watchdog set to 4 cycles)      |
// +------------------------------------------------------------------+
module tb_lsm_wb_master;

`ifdef LSM_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 0;
`endif

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0, wb_dat_i = '0;
  logic [1:0]  req_size_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [31:0] rsp_rdata_o, wb_adr_o, wb_dat_o;
  logic [4:0]  rsp_rd_o;
  logic [3:0]  wb_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  lsm_wb_master #(.TIMEOUT_CYCLES(TB_TMO == 0 ? 255 : TB_TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_rd_i(req_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o),
    .rsp_err_o(rsp_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          stb_cycles;
    bit          stb_stable;
    bit          cyc_seen;
    bit          ready_c1;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we;
    int          rsp_count;
    int          rsp_cycle;
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  rd;
  } txn_obs_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit model_mis(logic [31:0] addr, logic [1:0] size);
    return (size == 2'd3) || ((addr % nbytes(size)) != 0);
  endfunction

  function automatic logic [3:0] model_sel(logic [31:0] addr, logic [1:0] size);
    int lanes = (1 << nbytes(size)) - 1;
    return 4'(lanes << (addr % 4));
  endfunction

  function automatic logic [31:0] model_dat(logic [31:0] w, logic [1:0] size);
    logic [31:0] r;
    int nb = nbytes(size);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(k % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] d, logic [31:0] addr,
                                             logic [1:0] size, logic uns);
    int bits = 8 * nbytes(size);
    logic [31:0] v, mask;
    v    = d >> (8 * (addr % 4));
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v    = v & mask;
    if (!uns && bits < 32 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Bus cycles needed: REQUEST (1 + stalls) plus WAIT_ACK (ack delay + ack cycle).
  function automatic bit tmo_hit(int stall_n, int ackd);
    if (TB_TMO == 0) return 1'b0;
    if (ackd < 0) return 1'b1;
    return ((stall_n + 1) + (ackd + 1)) > TB_TMO;
  endfunction

  function automatic int exp_rsp_cycle(bit mis, int stall_n, int ackd);
    if (mis) return 2;
    if (tmo_hit(stall_n, ackd)) return TB_TMO + 2;
    return 3 + stall_n + ackd;
  endfunction

  function automatic int exp_stb_cycles(int stall_n, int ackd);
    if (tmo_hit(stall_n, ackd) && stall_n + 1 > TB_TMO) return TB_TMO;
    return stall_n + 1;
  endfunction

  // ---------------- driver / slave ----------------
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [4:0] rd,
                         input int stall_n, input int ackd, input logic [31:0] sdata,
                         input bit noise, output txn_obs_t o);
    int  stall_left = stall_n;
    int  ack_wait   = 0;
    bit  acked      = 1'b0;
    o = '{stb_cycles: 0, stb_stable: 1'b1, cyc_seen: 1'b0, ready_c1: 1'b0, adr: '0, dat: '0,
          sel: '0, we: 1'b0, rsp_count: 0, rsp_cycle: -1, rdata: '0, err: 1'b0, rd: '0};
    for (int n = 0; n < 20 && !req_ready_o; n++) tick();
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_size_i = size; req_unsigned_i = uns; req_rd_i = rd;
    tick();
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
    req_we_i = 1'($urandom); req_size_i = 2'($urandom); req_rd_i = 5'($urandom);
    for (int c = 1; c <= 80; c++) begin
      if (c == 1) o.ready_c1 = req_ready_o;
      if (wb_cyc_o) o.cyc_seen = 1'b1;
      if (wb_stb_o) begin
        if (o.stb_cycles == 0) begin
          o.adr = wb_adr_o; o.dat = wb_dat_o; o.sel = wb_sel_o; o.we = wb_we_o;
        end else if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {o.adr, o.dat, o.sel, o.we})
          o.stb_stable = 1'b0;
        o.stb_cycles++;
      end
      if (rsp_valid_o) begin
        if (o.rsp_count == 0) begin
          o.rsp_cycle = c; o.rdata = rsp_rdata_o; o.err = rsp_err_o; o.rd = rsp_rd_o;
        end
        o.rsp_count++;
      end else if (o.rsp_count > 0) break;
      wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = $urandom;
      if (wb_stb_o) begin
        if (stall_left > 0) begin wb_stall_i = 1'b1; stall_left--; end
        if (noise) wb_ack_i = 1'($urandom_range(0, 1));
      end else if (wb_cyc_o && !acked && ackd >= 0) begin
        if (ack_wait == ackd) begin wb_ack_i = 1'b1; wb_dat_i = sdata; acked = 1'b1; end
        ack_wait++;
      end
      tick();
    end
    wb_stall_i = 1'b0; wb_ack_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_i = 1'b0;
    #12;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== '0) begin
      n_errors++; $display("FAIL reset_wb: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want all 0",
                           wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
    end
    n_checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o} !== '0) begin
      n_errors++; $display("FAIL reset_rsp: got v=%b e=%b rd=%h rdata=%h want all 0",
                           rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o);
    end
    tick();
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_word_load;
    txn_obs_t o;
    run_txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5'd7, 0, 0, 32'hDEADBEEF, 1'b0, o);
    n_checks++; if (o.adr !== 32'h100) begin n_errors++; $display("FAIL word_load adr: got %h want 00000100", o.adr); end
    n_checks++; if (o.sel !== 4'hF) begin n_errors++; $display("FAIL word_load sel: got %h want f", o.sel); end
    n_checks++; if (o.ready_c1 !== 1'b0) begin n_errors++; $display("FAIL word_load busy_ready: got %b want 0", o.ready_c1); end
    n_checks++; if (o.rsp_cycle != 3) begin n_errors++; $display("FAIL word_load latency: got %0d want 3", o.rsp_cycle); end
    n_checks++; if (o.rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL word_load rdata: got %h want deadbeef", o.rdata); end
    n_checks++; if (o.err !== 1'b0 || o.rd !== 5'd7) begin n_errors++; $display("FAIL word_load err/rd: got %b/%0d want 0/7", o.err, o.rd); end
    n_checks++; if (o.rsp_count != 1) begin n_errors++; $display("FAIL word_load pulse: got %0d cycles want 1", o.rsp_count); end
  endtask

  task automatic test_byte_load;
    txn_obs_t o;
    run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 5'd3, 0, 1, 32'h80123456, 1'b0, o);
    n_checks++; if (o.sel !== 4'b1000) begin n_errors++; $display("FAIL byte_load sel: got %b want 1000", o.sel); end
    n_checks++; if (o.rdata !== 32'hFFFFFF80) begin n_errors++; $display("FAIL byte_load signed: got %h want ffffff80", o.rdata); end
    run_txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 5'd3, 0, 0, 32'h80123456, 1'b0, o);
    n_checks++; if (o.rdata !== 32'h00000080) begin n_errors++; $display("FAIL byte_load unsigned: got %h want 00000080", o.rdata); end
  endtask

  task automatic test_half_store_stall;
    txn_obs_t o;
    run_txn(1'b1, 32'h202, 32'h0000ABCD, 2'd1, 1'b0, 5'd9, 3, 0, 32'h12345678, 1'b0, o);
    n_checks++; if (o.stb_cycles != exp_stb_cycles(3, 0) || !o.stb_stable) begin
      n_errors++; $display("FAIL half_store stb: got %0d cycles stable=%b want %0d stable", o.stb_cycles, o.stb_stable, exp_stb_cycles(3, 0)); end
    n_checks++; if ({o.adr, o.sel, o.we} !== {32'h200, 4'b1100, 1'b1}) begin
      n_errors++; $display("FAIL half_store bus: got adr=%h sel=%b we=%b want 00000200/1100/1", o.adr, o.sel, o.we); end
    n_checks++; if (o.dat !== 32'hABCDABCD) begin n_errors++; $display("FAIL half_store dat: got %h want abcdabcd", o.dat); end
    n_checks++; if (o.rdata !== 32'h0 || o.err !== tmo_hit(3, 0)) begin
      n_errors++; $display("FAIL half_store rsp: got rdata=%h err=%b want 0/%b", o.rdata, o.err, tmo_hit(3, 0)); end
    n_checks++; if (o.rsp_cycle != exp_rsp_cycle(1'b0, 3, 0)) begin
      n_errors++; $display("FAIL half_store latency: got %0d want %0d", o.rsp_cycle, exp_rsp_cycle(1'b0, 3, 0)); end
  endtask

  task automatic test_misaligned;
    txn_obs_t o;
    run_txn(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 5'd21, 0, 0, 32'hFFFFFFFF, 1'b0, o);
    n_checks++; if (o.cyc_seen !== 1'b0) begin n_errors++; $display("FAIL misaligned bus: got cyc activity want none"); end
    n_checks++; if (o.rsp_cycle != 2 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.rd !== 5'd21) begin
      n_errors++; $display("FAIL misaligned rsp: got cyc=%0d err=%b rdata=%h rd=%0d want 2/1/0/21", o.rsp_cycle, o.err, o.rdata, o.rd); end
    run_txn(1'b1, 32'h40, 32'h0, 2'd3, 1'b0, 5'd2, 0, 0, 32'h0, 1'b0, o);
    n_checks++; if (o.cyc_seen !== 1'b0 || o.err !== 1'b1 || o.rsp_cycle != 2) begin
      n_errors++; $display("FAIL reserved_size: got cyc_seen=%b err=%b at %0d want 0/1/2", o.cyc_seen, o.err, o.rsp_cycle); end
  endtask

  task automatic test_reset_midflight;
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !req_ready_o; n++) tick();
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h40; req_size_i = 2'd2; req_rd_i = 5'd4;
    tick();
    req_valid_i = 1'b0;
    for (int n = 0; n < 10 && !(wb_cyc_o && !wb_stb_o); n++) tick();
    n_checks++; if (!(wb_cyc_o && !wb_stb_o)) begin n_errors++; $display("FAIL midreset reach_wait: got cyc=%b stb=%b want 1/0", wb_cyc_o, wb_stb_o); end
    #1 rst_i = 1'b0;
    #1;
    n_checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
      n_errors++; $display("FAIL midreset drop: got cyc=%b stb=%b want 0/0", wb_cyc_o, wb_stb_o); end
    tick(); tick();
    rst_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h5555AAAA;
    tick();
    wb_ack_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (rsp_valid_o || wb_cyc_o) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL midreset rsp: got stray response/bus activity want none"); end
    n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL midreset ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_timeout;
    txn_obs_t o;
    bit seen = 1'b0;
    run_txn(1'b0, 32'h80, 32'h0, 2'd2, 1'b0, 5'd11, 0, -1, 32'h0, 1'b0, o);
    n_checks++; if (o.cyc_seen !== 1'b1 || wb_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL timeout cyc: got seen=%b now=%b want 1/0", o.cyc_seen, wb_cyc_o); end
    n_checks++; if (o.rsp_count != 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.rsp_cycle != TB_TMO + 2) begin
      n_errors++; $display("FAIL timeout rsp: got n=%0d err=%b rdata=%h at %0d want 1/1/0/%0d", o.rsp_count, o.err, o.rdata, o.rsp_cycle, TB_TMO + 2); end
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
    tick();
    wb_ack_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (rsp_valid_o || wb_cyc_o) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL timeout late_ack: got second response want none"); end
  endtask

  task automatic test_random;
    txn_obs_t    o;
    logic        we, uns, err;
    logic [31:0] addr, wdata, sdata, rdata;
    logic [1:0]  size;
    logic [4:0]  rd;
    int          stall_n, ackd, ecyc;
    bit          mis, noise;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom); uns = 1'($urandom); addr = $urandom; wdata = $urandom; sdata = $urandom;
      size = 2'($urandom_range(0, 3)); rd = 5'($urandom);
      stall_n = $urandom_range(0, 3); ackd = $urandom_range(0, 3); noise = 1'($urandom_range(0, 1));
      run_txn(we, addr, wdata, size, uns, rd, stall_n, ackd, sdata, noise, o);
      mis   = model_mis(addr, size);
      err   = mis || tmo_hit(stall_n, ackd);
      rdata = (err || we) ? 32'h0 : model_load(sdata, addr, size, uns);
      ecyc  = exp_rsp_cycle(mis, stall_n, ackd);
      n_checks++; if (o.rsp_count != 1 || o.rsp_cycle != ecyc || o.ready_c1 !== 1'b0) begin
        n_errors++; $display("FAIL rand[%0d] timing: got n=%0d at %0d ready1=%b want 1 at %0d ready1=0", i, o.rsp_count, o.rsp_cycle, o.ready_c1, ecyc); end
      n_checks++; if (o.err !== err || o.rdata !== rdata || o.rd !== rd) begin
        n_errors++; $display("FAIL rand[%0d] rsp: got err=%b rdata=%h rd=%0d want %b/%h/%0d", i, o.err, o.rdata, o.rd, err, rdata, rd); end
      n_checks++; if (o.cyc_seen !== !mis) begin
        n_errors++; $display("FAIL rand[%0d] bus_activity: got %b want %b", i, o.cyc_seen, !mis); end
      if (!mis) begin
        n_checks++;
        if (o.adr !== {addr[31:2], 2'b00} || o.sel !== model_sel(addr, size) || o.we !== we ||
            o.stb_cycles != exp_stb_cycles(stall_n, ackd) || !o.stb_stable) begin
          n_errors++; $display("FAIL rand[%0d] bus: got adr=%h sel=%b we=%b stb=%0d stable=%b want %h/%b/%b/%0d/1",
                               i, o.adr, o.sel, o.we, o.stb_cycles, o.stb_stable, {addr[31:2], 2'b00},
                               model_sel(addr, size), we, exp_stb_cycles(stall_n, ackd));
        end
      end
      if (!mis && we) begin
        n_checks++; if (o.dat !== model_dat(wdata, size)) begin
          n_errors++; $display("FAIL rand[%0d] wdata: got %h want %h", i, o.dat, model_dat(wdata, size)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store_stall();
    test_misaligned();
    test_reset_midflight();
    if (TB_TMO != 0) test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
